// File: rtl/add8_err_monitor.sv
// Error-statistics monitor for an approximate 8-bit adder under test.
// Three-stage pipeline (exact sum, |error| and square, accumulate) under an IDLE/RUN/DRAIN/DONE FSM.
module add8_err_monitor #(
    parameter int CNT_W     = 17,
    parameter int N_SAMPLES = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         A,
    input  logic [7:0]         B,
    input  logic [8:0]         O,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W+8:0]   sum_abs_err,
    output logic [CNT_W+17:0]  sum_sq_err,
    output logic [8:0]         wce
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    state_t      r_state;
    logic [1:0]  r_drain;

    logic        r_s1_v;
    logic [8:0]  r_s1_exact;
    logic [8:0]  r_s1_o;
    logic        r_s2_v;
    logic [8:0]  r_s2_e;
    logic [17:0] r_s2_sq;

    logic        w_hs;
    logic        w_last;
    logic [9:0]  w_diff;
    logic [9:0]  w_neg;
    logic [8:0]  w_e;

    assign w_hs   = in_valid & in_ready;
    assign w_last = w_hs & (sample_cnt == LAST);
    assign w_diff = {1'b0, r_s1_o} - {1'b0, r_s1_exact};
    assign w_neg  = -w_diff;
    assign w_e    = w_diff[9] ? w_neg[8:0] : w_diff[8:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_exact <= '0;
            r_s1_o     <= '0;
            r_s2_v     <= 1'b0;
            r_s2_e     <= '0;
            r_s2_sq    <= '0;
        end else if (clear) begin
            r_s1_v     <= 1'b0;
            r_s1_exact <= '0;
            r_s1_o     <= '0;
            r_s2_v     <= 1'b0;
            r_s2_e     <= '0;
            r_s2_sq    <= '0;
        end else begin
            r_s1_v     <= w_hs;
            r_s1_exact <= {1'b0, A} + {1'b0, B};
            r_s1_o     <= O;
            r_s2_v     <= r_s1_v;
            r_s2_e     <= w_e;
            r_s2_sq    <= 18'(w_e) * 18'(w_e);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain     <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            wce         <= '0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_drain     <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            wce         <= '0;
        end else begin
            if (w_hs)
                sample_cnt <= sample_cnt + CNT_W'(1);
            if (r_s2_v) begin
                sum_abs_err <= sum_abs_err + {{CNT_W{1'b0}}, r_s2_e};
                sum_sq_err  <= sum_sq_err + {{CNT_W{1'b0}}, r_s2_sq};
                err_cnt     <= err_cnt + {{(CNT_W-1){1'b0}}, |r_s2_e};
                if (r_s2_e > wce)
                    wce <= r_s2_e;
            end
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    // The pipeline is empty here, so zeroing cannot lose a sample
                    if (start) begin
                        r_state     <= S_RUN;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        sample_cnt  <= '0;
                        err_cnt     <= '0;
                        sum_abs_err <= '0;
                        sum_sq_err  <= '0;
                        wce         <= '0;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state  <= S_DRAIN;
                        r_drain  <= '0;
                        in_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 2'd2) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Randomized and directed bench for add8_err_monitor, five instances
// with different run lengths sharing one stimulus bus.
module tb_add8_err_monitor;

    localparam int NI = 5;
    localparam int NS [NI] = '{4, 2, 3, 1, 65536};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [8:0] O = '0;

    logic        rdy  [NI];
    logic        bsy  [NI];
    logic        dn   [NI];
    logic [16:0] sc   [NI];
    logic [16:0] ec   [NI];
    logic [25:0] sa   [NI];
    logic [34:0] ss   [NI];
    logic [8:0]  wc   [NI];

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];
    int qo[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        add8_err_monitor #(.CNT_W(17), .N_SAMPLES(NS[g])) u_dut (
            .clk(clk), .rst(rst), .start(start), .clear(clear),
            .in_valid(in_valid), .in_ready(rdy[g]),
            .A(A), .B(B), .O(O),
            .busy(bsy[g]), .done(dn[g]),
            .sample_cnt(sc[g]), .err_cnt(ec[g]),
            .sum_abs_err(sa[g]), .sum_sq_err(ss[g]), .wce(wc[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input int k);
        chk({tag, " ready"}, 64'(rdy[k]), 0);
        chk({tag, " busy"}, 64'(bsy[k]), 0);
        chk({tag, " done"}, 64'(dn[k]), 0);
        chk({tag, " sample_cnt"}, 64'(sc[k]), 0);
        chk({tag, " err_cnt"}, 64'(ec[k]), 0);
        chk({tag, " sum_abs"}, 64'(sa[k]), 0);
        chk({tag, " sum_sq"}, 64'(ss[k]), 0);
        chk({tag, " wce"}, 64'(wc[k]), 0);
    endtask

    task automatic push(input int a, input int b, input int o);
        qa.push_back(a);
        qb.push_back(b);
        qo.push_back(o);
    endtask

    // Full run on instance k using the first n queued samples
    task automatic run(input string tag, input int k, input int n,
                       input int gap_pct, input bit do_clear,
                       input bit poke_start);
        longint e_abs = 0;
        longint e_sq = 0;
        longint e_cnt = 0;
        longint e_wce = 0;
        int h = 0;
        int budget = 0;
        bit hs;
        for (int i = 0; i < n; i++) begin
            int e = qo[i] - (qa[i] + qb[i]);
            if (e < 0) e = -e;
            e_abs += e;
            e_sq += longint'(e) * e;
            if (e != 0) e_cnt++;
            if (e > e_wce) e_wce = e;
        end
        if (do_clear) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " run busy"}, 64'(bsy[k]), 1);
        chk({tag, " run cnt0"}, 64'(sc[k]), 0);
        chk({tag, " run wce0"}, 64'(wc[k]), 0);
        while (h < n && budget < n * 20 + 100) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            A = 8'(qa[h]);
            B = 8'(qb[h]);
            O = 9'(qo[h]);
            start = poke_start && (h == 1);
            if (n < 1000 || h == 0)
                chk({tag, " ready"}, 64'(rdy[k]), 1);
            hs = in_valid && rdy[k];
            tick();
            start = 1'b0;
            if (hs) h++;
            if (n < 1000 || h == n)
                chk({tag, " cnt"}, 64'(sc[k]), 64'(h));
            budget++;
        end
        chk({tag, " handshakes"}, 64'(h), 64'(n));
        in_valid = 1'b1;
        A = 8'($urandom);
        B = 8'($urandom);
        O = 9'($urandom);
        chk({tag, " ready drop"}, 64'(rdy[k]), 0);
        chk({tag, " drain busy"}, 64'(bsy[k]), 1);
        tick();
        tick();
        chk({tag, " done early"}, 64'(dn[k]), 0);
        tick();
        chk({tag, " done"}, 64'(dn[k]), 1);
        chk({tag, " busy end"}, 64'(bsy[k]), 0);
        chk({tag, " ready end"}, 64'(rdy[k]), 0);
        chk({tag, " sample_cnt"}, 64'(sc[k]), 64'(n));
        chk({tag, " err_cnt"}, 64'(ec[k]), 64'(e_cnt));
        chk({tag, " sum_abs"}, 64'(sa[k]), 64'(e_abs));
        chk({tag, " sum_sq"}, 64'(ss[k]), 64'(e_sq));
        chk({tag, " wce"}, 64'(wc[k]), 64'(e_wce));
        tick();
        in_valid = 1'b0;
        chk({tag, " held done"}, 64'(dn[k]), 1);
        chk({tag, " held cnt"}, 64'(sc[k]), 64'(n));
        chk({tag, " held abs"}, 64'(sa[k]), 64'(e_abs));
    endtask

    initial begin
        tick();
        tick();
        for (int k = 0; k < NI; k++)
            chk_zero("reset", k);
        rst = 1'b0;
        tick();

        push(1, 2, 3); push(10, 5, 12); push(255, 255, 510); push(0, 0, 0);
        run("basic4", 0, 4, 0, 1'b1, 1'b0);

        qa = {}; qb = {}; qo = {};
        push(200, 100, 0); push(0, 0, 511);
        run("max2", 1, 2, 0, 1'b1, 1'b0);
        chk("max2 literal sq", 64'(ss[1]), 351121);

        qa = {}; qb = {}; qo = {};
        for (int i = 0; i < 3; i++)
            push($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 511));
        run("gaps3", 2, 3, 50, 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            qa = {}; qb = {}; qo = {};
            for (int i = 0; i < 4; i++) begin
                int a = $urandom_range(0, 255);
                int b = $urandom_range(0, 255);
                push(a, b, $urandom_range(0, 1) ? a + b : $urandom_range(0, 511));
            end
            run("rand4", 0, 4, 30, 1'b0, 1'b1);
        end

        // Abort two samples into a run; in-flight samples must vanish
        qa = {}; qb = {}; qo = {};
        push(9, 9, 100); push(50, 50, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            A = 8'(qa[i]); B = 8'(qb[i]); O = 9'(qo[i]);
            tick();
        end
        chk("clr pre cnt", 64'(sc[0]), 2);
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_zero("clr now", 0);
        tick();
        tick();
        tick();
        chk_zero("clr later", 0);

        // Asynchronous reset in the middle of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        A = 8'd100; B = 8'd100; O = 9'd0;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst pre cnt", 64'(sc[0]), 2);
        rst = 1'b1;
        #1;
        chk_zero("rst async", 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("rst no accept", 64'(sc[3]), 0);
        chk("rst no ready", 64'(rdy[3]), 0);
        in_valid = 1'b0;
        qa = {}; qb = {}; qo = {};
        push(3, 4, 8);
        run("post rst", 3, 1, 0, 1'b0, 1'b0);

        qa = {}; qb = {}; qo = {};
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                push(a, b, a + b);
        run("exhaust", 4, 65536, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
